console_writer: RTL
===================

Name: console_writer

Overview:
- Upstream feeder for the character generator. Consumes a byte stream over a valid/ready handshake and interprets it as terminal text: printable glyphs, CR, LF and BS.
- Drives the char buffer write port (address, data, write enable) and the first-char (scroll origin) register.
- Maintains the cursor position, performs hardware scrolling by rotating the circular buffer, and blanks new lines. The whole screen is blanked after reset.

Parameters:
- ROWS, 25, text rows on screen
- COLS, 80, text columns per row
- ROW_BITS, 5, width of cursor_row
- COL_BITS, 7, width of cursor_col
- ADDR_BITS, 11, char buffer address width
- BLANK_CHAR, 8'h20, code written when clearing

Ports:
- clk  in  1  pixel clock (single clock domain)
- clr_n  in  1  asynchronous active-low reset
- in_data  in  8  incoming byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- buffer_waddr  out  ADDR_BITS  char buffer write address
- buffer_din  out  8  char buffer write data
- buffer_wen  out  1  char buffer write strobe
- buffer_first_char  out  ADDR_BITS  new scroll origin
- buffer_first_char_wen  out  1  one-cycle strobe loading buffer_first_char
- cursor_row  out  ROW_BITS  current cursor row, 0..ROWS-1
- cursor_col  out  COL_BITS  current cursor column, 0..COLS-1
- busy  out  1  high while a clear sequence is running (equals ~in_ready)

Behaviour:
- Single clock (clk). Reset is asynchronous and active-low on clr_n. All outputs are registered.
- Reset values: cursor_row=0, cursor_col=0, buffer_first_char=0, buffer_waddr=0, buffer_din=0, buffer_wen=0, buffer_first_char_wen=0, in_ready=0, busy=1.
- Internal state:
  - first_char: always a multiple of COLS, < ROWS*COLS.
  - line_base: buffer address of the cursor row = (first_char + cursor_row*COLS) mod ROWS*COLS. Updated incrementally, never by multiplication.
  - Write address = line_base + cursor_col. This never wraps, because each line is contiguous.
- FSM states: INIT_CLEAR, IDLE, LINE_CLEAR, SCROLL.
- INIT_CLEAR (entered at reset deassertion):
  - Writes BLANK_CHAR to addresses 0..ROWS*COLS-1, one per cycle, buffer_wen=1 each cycle (2000 cycles at defaults).
  - Then goes to IDLE.
- IDLE:
  - in_ready=1. A byte is accepted when in_valid && in_ready.
  - Effects appear on the outputs in the next cycle (latency 1).
  - One byte at most per cycle.
- Byte handling in IDLE:
  - 0x20..0x7E: write byte to line_base+cursor_col (buffer_wen=1 for one cycle).
    - If cursor_col<COLS-1: cursor_col++.
    - Else: auto-wrap, cursor_col=0, then newline handling as for LF.
  - 0x0D (CR): cursor_col=0, no write.
  - 0x0A (LF), newline handling:
    - If cursor_row<ROWS-1: cursor_row++ and line_base += COLS, wrapping mod ROWS*COLS.
    - If cursor_row==ROWS-1: start a scroll. The new bottom line occupies the old top line's storage, so clear_base = first_char. Go to LINE_CLEAR.
  - 0x08 (BS): if cursor_col>0, cursor_col--. At column 0, no effect. No erase.
  - All other bytes: consumed and ignored; no state change.
- LINE_CLEAR:
  - in_ready=0.
  - Writes BLANK_CHAR to clear_base..clear_base+COLS-1 on COLS consecutive cycles.
  - Then goes to SCROLL.
- SCROLL (1 cycle):
  - first_char = first_char+COLS, or 0 if the sum equals ROWS*COLS.
  - Drives buffer_first_char with the new value and pulses buffer_first_char_wen for exactly one cycle.
  - line_base = old first_char; cursor_row stays ROWS-1.
  - Returns to IDLE; in_ready=1 the following cycle.
- The auto-wrap write and the following scroll use the same path: write cycle first, then LINE_CLEAR. No byte is accepted in between.
- buffer_wen and buffer_first_char_wen are never asserted in the same cycle.
- buffer_waddr and buffer_din are held when no strobe is active.
- Reset mid-clear or mid-scroll: all state is discarded immediately; after clr_n rises the block restarts INIT_CLEAR with first_char=0.

Test Plan:
- Release reset, count buffer_wen -> exactly 2000 writes of 8'h20 covering addresses 0..1999 with no gaps. in_ready rises on the cycle after the last write. cursor=(0,0).
- Send "AB" -> writes 0x41@0, then 0x42@1, each one cycle after acceptance; cursor_col=2. Then BS, BS, BS -> cursor_col 1, 0, 0.
- Send 24 LF, then 'X' -> no scroll and no buffer_first_char_wen; 'X' written @1920; cursor=(24,1).
- From cursor row 24 with first_char=0, send LF -> in_ready low for 81 cycles. 80 writes of 0x20 @0..79, then buffer_first_char=80 strobed once. Then 'Y' is written @0; cursor=(24,1).
- Issue 25 scrolls from reset -> buffer_first_char sequence 80, 160, …, 1920, 0. The wrap to 0 is observed on the 25th scroll.
- Fill row 0 with 80 printables while at row 24 -> 80th char written @line_base+79, then a line clear and scroll follow automatically. Assert clr_n low during that clear -> all outputs at reset values immediately, then a full 2000-write clear restarts.

Source files
------------

// File: rtl/console_writer.sv
// Terminal-style byte sink feeding the character generator's text buffer.
// Handles glyphs, CR, LF and BS; owns the cursor and hardware scrolling.
//
// Ports:
//   clk, clr_n               clock, async active-low reset
//   in_data/in_valid/in_ready byte stream handshake
//   buffer_waddr/din/wen     char buffer write port
//   buffer_first_char(_wen)  scroll origin load
//   cursor_row/cursor_col    current cursor
//   busy                     clear in progress (~in_ready)
module console_writer #(
  parameter int          ROWS       = 25,
  parameter int          COLS       = 80,
  parameter int          ROW_BITS   = 5,
  parameter int          COL_BITS   = 7,
  parameter int          ADDR_BITS  = 11,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col,
  output logic                 busy
);

  localparam int TOTAL = ROWS * COLS;

  localparam logic [ADDR_BITS:0] TOTAL_W =
    (ADDR_BITS+1)'(TOTAL);
  localparam logic [ADDR_BITS:0] COLS_W =
    (ADDR_BITS+1)'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR =
    ADDR_BITS'(TOTAL - 1);
  localparam logic [ADDR_BITS-1:0] LAST_CNT =
    ADDR_BITS'(COLS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL =
    COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW =
    ROW_BITS'(ROWS - 1);

  typedef enum logic [1:0] {
    S_INIT_CLEAR,
    S_IDLE,
    S_LINE_CLEAR,
    S_SCROLL
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] fc_q, fc_d;
  logic [ADDR_BITS-1:0] lb_q, lb_d;
  logic [ADDR_BITS-1:0] clr_base_q, clr_base_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]           din_q, din_d;
  logic                 wen_q, wen_d;
  logic                 fcwen_q, fcwen_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic is_print;
  logic is_cr;
  logic is_lf;
  logic is_bs;
  logic do_nl;

  // Advance one line in the circular buffer.
  function automatic logic [ADDR_BITS-1:0] next_line(
    input logic [ADDR_BITS-1:0] base
  );
    logic [ADDR_BITS:0] s;
    s = {1'b0, base} + COLS_W;
    if (s >= TOTAL_W) s = s - TOTAL_W;
    return s[ADDR_BITS-1:0];
  endfunction

  assign accept   = ready_q && in_valid;
  assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7e);
  assign is_cr    = (in_data == 8'h0d);
  assign is_lf    = (in_data == 8'h0a);
  assign is_bs    = (in_data == 8'h08);

  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    lb_d       = lb_q;
    clr_base_d = clr_base_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    waddr_d    = waddr_q;
    din_d      = din_q;
    wen_d      = 1'b0;
    fcwen_d    = 1'b0;
    ready_d    = 1'b0;
    do_nl      = 1'b0;

    unique case (state_q)
      S_INIT_CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        din_d   = BLANK_CHAR;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          unique case (1'b1)
            is_print: begin
              wen_d   = 1'b1;
              waddr_d = lb_q + ADDR_BITS'(col_q);
              din_d   = in_data;
              if (col_q == LAST_COL) begin
                col_d = '0;
                do_nl = 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            is_cr: col_d = '0;
            is_lf: do_nl = 1'b1;
            is_bs: begin
              if (col_q != '0) col_d = col_q - 1'b1;
            end
            default: ;
          endcase

          if (do_nl) begin
            if (row_q == LAST_ROW) begin
              // New bottom line reuses the old top line.
              clr_base_d = fc_q;
              cnt_d      = '0;
              state_d    = S_LINE_CLEAR;
              ready_d    = 1'b0;
            end else begin
              row_d = row_q + 1'b1;
              lb_d  = next_line(lb_q);
            end
          end
        end
      end

      S_LINE_CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = clr_base_q + cnt_q;
        din_d   = BLANK_CHAR;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_SCROLL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SCROLL: begin
        fc_d    = next_line(fc_q);
        fcwen_d = 1'b1;
        lb_d    = fc_q;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_INIT_CLEAR;
    endcase

    busy_d = ~ready_d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_INIT_CLEAR;
      fc_q       <= '0;
      lb_q       <= '0;
      clr_base_q <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      waddr_q    <= '0;
      din_q      <= '0;
      wen_q      <= 1'b0;
      fcwen_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      lb_q       <= lb_d;
      clr_base_q <= clr_base_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      fcwen_q    <= fcwen_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready              = ready_q;
  assign busy                  = busy_q;
  assign buffer_waddr          = waddr_q;
  assign buffer_din            = din_q;
  assign buffer_wen            = wen_q;
  assign buffer_first_char     = fc_q;
  assign buffer_first_char_wen = fcwen_q;
  assign cursor_row            = row_q;
  assign cursor_col            = col_q;

endmodule
